// File: rtl/npu_port_arbiter_if.sv
// Bundle of requester-side and NPU-side signals for the NPU port arbiter.
// The arbiter takes the slave view; the environment/requesters take the master view.
interface npu_port_arbiter_if #(
    parameter int unsigned DWidth = 32,
    parameter int unsigned NumReq = 2
);
    logic [NumReq-1:0]        req_i;
    logic [NumReq-1:0]        write_i;
    logic [NumReq*DWidth-1:0] addr_i;
    logic [NumReq*DWidth-1:0] wdata_i;
    logic [NumReq-1:0]        gnt_o;
    logic [NumReq-1:0]        rvalid_o;
    logic [DWidth-1:0]        rdata_o;
    logic                     cen_o;
    logic                     wen_o;
    logic [DWidth-1:0]        addr_o;
    logic [DWidth-1:0]        wdata_o;
    logic [DWidth-1:0]        rdata_i;

    modport slave (
        input  req_i, write_i, addr_i, wdata_i, rdata_i,
        output gnt_o, rvalid_o, rdata_o, cen_o, wen_o, addr_o, wdata_o
    );

    modport master (
        output req_i, write_i, addr_i, wdata_i, rdata_i,
        input  gnt_o, rvalid_o, rdata_o, cen_o, wen_o, addr_o, wdata_o
    );
endinterface

// File: rtl/npu_port_arbiter.sv
// Round-robin arbiter with bounded hold window sharing one NPU memory port;
// routes the 1-cycle-latency read data back to the requester that issued it.
module npu_port_arbiter #(
    parameter int unsigned DWidth  = 32,
    parameter int unsigned NumReq  = 2,
    parameter int unsigned MaxHold = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    npu_port_arbiter_if.slave bus
);
    localparam int unsigned     IdW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned     CntW   = $clog2(MaxHold + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxHold);

    logic [IdW-1:0]  owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rd_pend_q, rd_pend_d;
    logic [IdW-1:0]  rd_id_q, rd_id_d;

    logic [IdW-1:0]  win;
    logic [IdW-1:0]  cand;
    logic            win_vld;
    logic            others;
    logic            hold;

    always_comb begin
        others = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (IdW'(k) != owner_q && bus.req_i[IdW'(k)]) others = 1'b1;
        end

        hold    = owner_vld_q && bus.req_i[owner_q] && ((cnt_q < MaxCnt) || !others);
        win     = owner_q;
        win_vld = hold;
        cand    = '0;

        // Search starts just past the current owner, so an idle gap still restarts fairly.
        if (!hold) begin
            for (int unsigned i = 1; i <= NumReq; i++) begin
                cand = IdW'((32'(owner_q) + i) % NumReq);
                if (!win_vld && bus.req_i[cand]) begin
                    win_vld = 1'b1;
                    win     = cand;
                end
            end
        end

        owner_d     = owner_q;
        owner_vld_d = 1'b0;
        cnt_d       = '0;
        rd_pend_d   = 1'b0;
        rd_id_d     = rd_id_q;
        if (win_vld) begin
            owner_d     = win;
            owner_vld_d = 1'b1;
            if (owner_vld_q && win == owner_q) begin
                cnt_d = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + 1'b1;
            end else begin
                cnt_d = CntW'(1);
            end
            rd_pend_d = !bus.write_i[win];
            rd_id_d   = win;
        end
    end

    always_comb begin
        bus.gnt_o    = '0;
        bus.cen_o    = 1'b0;
        bus.wen_o    = 1'b0;
        bus.addr_o   = '0;
        bus.wdata_o  = '0;
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        // Outputs are forced quiet during reset, including a return still in flight.
        if (!rst_i) begin
            if (win_vld) begin
                bus.gnt_o[win] = 1'b1;
                bus.cen_o      = 1'b1;
                bus.wen_o      = bus.write_i[win];
                bus.addr_o     = bus.addr_i[32'(win)*DWidth +: DWidth];
                bus.wdata_o    = bus.wdata_i[32'(win)*DWidth +: DWidth];
            end
            if (rd_pend_q) begin
                bus.rvalid_o[rd_id_q] = 1'b1;
                bus.rdata_o           = bus.rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= '0;
        end else begin
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
        end
    end
endmodule

// File: tb/tb_npu_port_arbiter.sv
// Self-checking bench for npu_port_arbiter: directed scenarios plus a randomized
// run compared against a behavioural arbitration model.
module tb_npu_port_arbiter;
    localparam int MH = 4;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        cen;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rvalid;
        logic [31:0] rdata;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   fails   = 0;

    // Behavioural model state: current owner, unbounded run length, pending read.
    int   m_owner   = 0;
    bit   m_vld     = 1'b0;
    int   m_run     = 0;
    bit   m_pend    = 1'b0;
    int   m_pend_id = 0;

    npu_port_arbiter_if #(.DWidth(32), .NumReq(2)) bus ();
    npu_port_arbiter_if #(.DWidth(32), .NumReq(2)) bus1 ();

    npu_port_arbiter #(.DWidth(32), .NumReq(2), .MaxHold(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    npu_port_arbiter #(.DWidth(32), .NumReq(2), .MaxHold(1)) dut1 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus1)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [1:0] req);
        logic [1:0] rest;
        if (req == 2'b00) return -1;
        rest = req;
        rest[m_owner] = 1'b0;
        if (m_vld && req[m_owner] && (m_run < MH || rest == 2'b00)) return m_owner;
        for (int i = 1; i <= 2; i++) begin
            if (req[(m_owner + i) % 2]) return (m_owner + i) % 2;
        end
        return -1;
    endfunction

    function automatic obs_t model_expect();
        obs_t e;
        int   w;
        e = '0;
        if (rst) return e;
        w = pick(bus.req_i);
        if (w >= 0) begin
            e.gnt[w] = 1'b1;
            e.cen    = 1'b1;
            e.wen    = bus.write_i[w];
            e.addr   = bus.addr_i[w*32 +: 32];
            e.wdata  = bus.wdata_i[w*32 +: 32];
        end
        if (m_pend) begin
            e.rvalid[m_pend_id] = 1'b1;
            e.rdata             = bus.rdata_i;
        end
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.gnt    = bus.gnt_o;
        o.cen    = bus.cen_o;
        o.wen    = bus.wen_o;
        o.addr   = bus.addr_o;
        o.wdata  = bus.wdata_o;
        o.rvalid = bus.rvalid_o;
        o.rdata  = bus.rdata_o;
        return o;
    endfunction

    task automatic model_commit();
        int w;
        if (rst) begin
            m_owner = 0; m_vld = 1'b0; m_run = 0; m_pend = 1'b0; m_pend_id = 0;
            return;
        end
        w = pick(bus.req_i);
        if (w < 0) begin
            m_vld  = 1'b0;
            m_run  = 0;
            m_pend = 1'b0;
        end else begin
            m_run     = (m_vld && w == m_owner) ? m_run + 1 : 1;
            m_owner   = w;
            m_vld     = 1'b1;
            m_pend    = !bus.write_i[w];
            m_pend_id = w;
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [1:0] req, logic [1:0] wr, logic [31:0] a0, logic [31:0] a1,
                         logic [31:0] d0, logic [31:0] d1, logic [31:0] rdi);
        bus.req_i   = req;
        bus.write_i = wr;
        bus.addr_i  = {a1, a0};
        bus.wdata_i = {d1, d0};
        bus.rdata_i = rdi;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0);
        bus1.req_i = 2'b00;
        @(negedge clk);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t obs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom);
            @(negedge clk);
            obs = observe();
            vectors++;
            if (obs !== obs_t'(0)) begin
                fails++;
                $display("FAIL reset_outputs: got %h expected %h", obs, obs_t'(0));
            end
            tick();
        end
        rst = 1'b0;
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0);
    endtask

    task automatic test_single_read();
        obs_t obs, exp;
        do_reset();
        drive(2'b01, 2'b00, 32'h1000_0004, '0, '0, '0, 32'h1234_5678);
        @(negedge clk);
        obs = observe();
        vectors++;
        if ({obs.gnt, obs.cen, obs.wen, obs.addr, obs.rvalid} !== {2'b01, 1'b1, 1'b0, 32'h1000_0004, 2'b00}) begin
            fails++;
            $display("FAIL single_read_issue: got gnt=%b cen=%b wen=%b addr=%h rv=%b expected gnt=01 cen=1 wen=0 addr=10000004 rv=00",
                     obs.gnt, obs.cen, obs.wen, obs.addr, obs.rvalid);
        end
        tick();
        drive(2'b00, 2'b00, '0, '0, '0, '0, 32'hDEAD_BEEF);
        @(negedge clk);
        obs = observe();
        exp = model_expect();
        vectors++;
        if ({obs.rvalid, obs.rdata, obs.cen} !== {2'b01, 32'hDEAD_BEEF, 1'b0} || obs !== exp) begin
            fails++;
            $display("FAIL single_read_return: got %h expected rvalid=01 rdata=deadbeef (%h)", obs, exp);
        end
        tick();
    endtask

    task automatic test_contention();
        obs_t obs, exp;
        logic [1:0] want, prev;
        do_reset();
        prev = 2'b00;
        for (int i = 0; i < 12; i++) begin
            drive(2'b11, 2'b00, 32'h100 + i, 32'h200 + i, '0, '0, $urandom);
            @(negedge clk);
            obs  = observe();
            exp  = model_expect();
            want = ((i / 4) % 2 == 0) ? 2'b10 : 2'b01;
            vectors++;
            if (obs.gnt !== want || obs.rvalid !== prev || obs !== exp) begin
                fails++;
                $display("FAIL contention[%0d]: got gnt=%b rv=%b bus=%h expected gnt=%b rv=%b bus=%h",
                         i, obs.gnt, obs.rvalid, obs, want, prev, exp);
            end
            prev = want;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        obs_t obs;
        logic [31:0] rd;
        do_reset();
        drive(2'b01, 2'b01, 32'h1000_0008, '0, 32'h55, '0, 32'hAAAA_0000);
        @(negedge clk);
        obs = observe();
        vectors++;
        if ({obs.gnt, obs.wen, obs.addr, obs.wdata} !== {2'b01, 1'b1, 32'h1000_0008, 32'h55}) begin
            fails++;
            $display("FAIL b2b_write: got %h expected gnt=01 wen=1 addr=10000008 wdata=55", obs);
        end
        tick();
        drive(2'b10, 2'b00, '0, 32'h1000_0008, '0, '0, 32'hBBBB_0000);
        @(negedge clk);
        obs = observe();
        vectors++;
        if ({obs.gnt, obs.wen, obs.addr, obs.rvalid} !== {2'b10, 1'b0, 32'h1000_0008, 2'b00}) begin
            fails++;
            $display("FAIL b2b_read_issue: got gnt=%b wen=%b addr=%h rv=%b expected gnt=10 wen=0 addr=10000008 rv=00",
                     obs.gnt, obs.wen, obs.addr, obs.rvalid);
        end
        tick();
        rd = $urandom;
        drive(2'b00, 2'b00, '0, '0, '0, '0, rd);
        @(negedge clk);
        obs = observe();
        vectors++;
        if ({obs.rvalid, obs.rdata} !== {2'b10, rd}) begin
            fails++;
            $display("FAIL b2b_read_return: got rv=%b rdata=%h expected rv=10 rdata=%h", obs.rvalid, obs.rdata, rd);
        end
        tick();
    endtask

    task automatic test_lone();
        obs_t obs;
        int   want_cnt;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(2'b10, 2'b00, '0, 32'h300 + i, '0, '0, $urandom);
            @(negedge clk);
            obs = observe();
            vectors++;
            if (obs.gnt !== 2'b10 || obs.cen !== 1'b1) begin
                fails++;
                $display("FAIL lone_grant[%0d]: got gnt=%b cen=%b expected gnt=10 cen=1", i, obs.gnt, obs.cen);
            end
            tick();
            want_cnt = (i + 1 < MH) ? i + 1 : MH;
            vectors++;
            if (dut.cnt_q !== 3'(want_cnt)) begin
                fails++;
                $display("FAIL lone_cnt[%0d]: got %0d expected %0d", i, dut.cnt_q, want_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        obs_t obs;
        do_reset();
        drive(2'b01, 2'b00, 32'h44, '0, '0, '0, $urandom);
        @(negedge clk);
        tick();
        rst = 1'b1;
        drive(2'b00, 2'b00, '0, '0, '0, '0, 32'hCAFE_F00D);
        @(negedge clk);
        obs = observe();
        vectors++;
        if (obs !== obs_t'(0)) begin
            fails++;
            $display("FAIL reset_mid_read: got %h expected %h", obs, obs_t'(0));
        end
        tick();
        rst = 1'b0;
        drive(2'b11, 2'b00, 32'h50, 32'h60, '0, '0, $urandom);
        @(negedge clk);
        obs = observe();
        vectors++;
        if (obs.gnt !== 2'b10 || obs.rvalid !== 2'b00) begin
            fails++;
            $display("FAIL reset_restart: got gnt=%b rv=%b expected gnt=10 rv=00", obs.gnt, obs.rvalid);
        end
        tick();
    endtask

    task automatic test_idle_gap();
        obs_t obs;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(2'b01, 2'b01, 32'h70, '0, 32'h71, '0, '0);
            @(negedge clk);
            tick();
        end
        drive(2'b00, 2'b00, '0, '0, '0, '0, '0);
        @(negedge clk);
        tick();
        drive(2'b11, 2'b01, 32'h80, 32'h90, '0, '0, '0);
        @(negedge clk);
        obs = observe();
        vectors++;
        if (obs.gnt !== 2'b10 || obs.addr !== 32'h90) begin
            fails++;
            $display("FAIL idle_gap_grant: got gnt=%b addr=%h expected gnt=10 addr=00000090", obs.gnt, obs.addr);
        end
        tick();
        vectors++;
        if (dut.cnt_q !== 3'd1) begin
            fails++;
            $display("FAIL idle_gap_cnt: got %0d expected 1", dut.cnt_q);
        end
    endtask

    task automatic test_pure_rr();
        logic [1:0] want;
        do_reset();
        bus1.req_i   = 2'b11;
        bus1.write_i = 2'b00;
        bus1.addr_i  = '0;
        bus1.wdata_i = '0;
        bus1.rdata_i = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            vectors++;
            if (bus1.gnt_o !== want) begin
                fails++;
                $display("FAIL pure_rr[%0d]: got gnt=%b expected %b", i, bus1.gnt_o, want);
            end
            tick();
        end
        bus1.req_i = 2'b00;
    endtask

    task automatic test_random();
        obs_t        obs, exp;
        logic [1:0]  rq, wr, gl;
        logic [31:0] a0, a1, d0, d1;
        do_reset();
        rq = 2'b00; wr = 2'b00; gl = 2'b00;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 400; c++) begin
            if (!rq[0] || gl[0]) begin
                rq[0] = ($urandom_range(0, 99) < 60);
                wr[0] = 1'($urandom);
                a0 = $urandom; d0 = $urandom;
            end
            if (!rq[1] || gl[1]) begin
                rq[1] = ($urandom_range(0, 99) < 60);
                wr[1] = 1'($urandom);
                a1 = $urandom; d1 = $urandom;
            end
            rst = ($urandom_range(0, 49) == 0);
            drive(rq, wr, a0, a1, d0, d1, $urandom);
            @(negedge clk);
            obs = observe();
            exp = model_expect();
            vectors++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL random[%0d]: got %h expected %h", c, obs, exp);
            end
            gl = exp.gnt;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.req_i    = '0;
        bus.write_i  = '0;
        bus.addr_i   = '0;
        bus.wdata_i  = '0;
        bus.rdata_i  = '0;
        bus1.req_i   = '0;
        bus1.write_i = '0;
        bus1.addr_i  = '0;
        bus1.wdata_i = '0;
        bus1.rdata_i = '0;

        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_lone();
        test_reset_mid_read();
        test_idle_gap();
        test_pure_rr();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
